demux_1_3_reg: RTL and testbench

//  Registered 1-to-3 demultiplexer: the distribution counterpart of the 3:1 word mux.

---
 rtl/demux_1_3_reg_if.sv | 37 +++
 rtl/demux_1_3_reg.sv | 108 ++++++++++
 tb/tb_demux_1_3_reg.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_3_reg_if.sv
// Handshake bundle for the registered 1-to-3 demultiplexer: one producer-side
// stream in, three consumer-side valid/ready streams out, plus the transfer counter.
interface demux_1_3_reg_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] demux_input;
  logic              in_valid;
  logic              in_ready;
  logic              selector_1;
  logic              selector_2;
  logic [DATA_W-1:0] out_data_0;
  logic [DATA_W-1:0] out_data_1;
  logic [DATA_W-1:0] out_data_2;
  logic              out_valid_0;
  logic              out_valid_1;
  logic              out_valid_2;
  logic              out_ready_0;
  logic              out_ready_1;
  logic              out_ready_2;
  logic [CNT_W-1:0]  xfer_count;

  // Environment side: feeds the input stream and consumes the three channels.
  modport master (
    output demux_input, in_valid, selector_1, selector_2,
    output out_ready_0, out_ready_1, out_ready_2,
    input  in_ready, out_data_0, out_data_1, out_data_2,
    input  out_valid_0, out_valid_1, out_valid_2, xfer_count
  );

  modport slave (
    input  demux_input, in_valid, selector_1, selector_2,
    input  out_ready_0, out_ready_1, out_ready_2,
    output in_ready, out_data_0, out_data_1, out_data_2,
    output out_valid_0, out_valid_1, out_valid_2, xfer_count
  );
endinterface

// File: rtl/demux_1_3_reg.sv
// Registered 1-to-3 demultiplexer: each channel owns a one-entry holding register
// with valid/ready, so a stalled consumer only back-pressures words meant for it.
module demux_1_3_reg #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            reset_n,
  demux_1_3_reg_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

  logic [1:0]        sel;
  logic              in_ready;
  logic [2:0]        ready_vec;
  logic [2:0]        valid_vec;
  logic [2:0]        acc;
  logic [2:0]        take;
  chan_state_e       state_q   [3];
  chan_state_e       state_nxt [3];
  logic [DATA_W-1:0] data_q    [3];
  logic [CNT_W-1:0]  count_q;

  assign ready_vec = {bus.out_ready_2, bus.out_ready_1, bus.out_ready_0};

  // Same priority as the 3:1 word mux: selector_2 wins over selector_1.
  always_comb begin
    sel = 2'd0;
    if (bus.selector_2)      sel = 2'd2;
    else if (bus.selector_1) sel = 2'd1;
  end

  // Readiness looks only at the channel currently selected, never at in_valid.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_ready = 1'b0;
    case (sel)
      2'd0:    in_ready = !valid_vec[0] || ready_vec[0];
      2'd1:    in_ready = !valid_vec[1] || ready_vec[1];
      2'd2:    in_ready = !valid_vec[2] || ready_vec[2];
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    acc  = '0;
    take = '0;
    for (int i = 0; i < 3; i++) begin
      acc[i]  = bus.in_valid && in_ready && (sel == i[1:0]);
      take[i] = valid_vec[i] && ready_vec[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) state_q[i] <= EMPTY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < 3; i++) state_q[i] <= state_nxt[i];
    end
  end

  // Next-state logic; a refill in the delivery cycle keeps the channel FULL with no bubble.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt[i] = state_q[i];
      case (state_q[i])
        EMPTY:   if (acc[i]) state_nxt[i] = FULL;
        FULL:    if (take[i] && !acc[i]) state_nxt[i] = EMPTY;
        default: state_nxt[i] = EMPTY;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    for (int i = 0; i < 3; i++) valid_vec[i] = (state_q[i] == FULL);
  end

  // Holding registers are written only on acceptance, so data stays put under stall and after delivery.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the holding registers are reset too, because consumers see zeros while reset is low.
      for (int i = 0; i < 3; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) data_q[i] <= bus.demux_input;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        count_q <= '0;
    else if (|acc)       count_q <= count_q + 1'b1;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid_0 = valid_vec[0];
  assign bus.out_valid_1 = valid_vec[1];
  assign bus.out_valid_2 = valid_vec[2];
  assign bus.out_data_0  = data_q[0];
  assign bus.out_data_1  = data_q[1];
  assign bus.out_data_2  = data_q[2];
  assign bus.xfer_count  = count_q;

endmodule

// File: tb/tb_demux_1_3_reg.sv
// Self-checking bench for demux_1_3_reg: per-channel scoreboard queues are filled
// on accepted input words and drained when the consumer takes the word.
module tb_demux_1_3_reg;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  demux_1_3_reg_if #(.DATA_W(16), .CNT_W(16)) bus ();

  demux_1_3_reg #(.DATA_W(16), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] mdata [3];
  logic [15:0] mcnt;
  int          delivered [3];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dout(input int n);
    case (n)
      0:       return bus.out_data_0;
      1:       return bus.out_data_1;
      default: return bus.out_data_2;
    endcase
  endfunction

  function automatic logic vout(input int n);
    case (n)
      0:       return bus.out_valid_0;
      1:       return bus.out_valid_1;
      default: return bus.out_valid_2;
    endcase
  endfunction

  function automatic int qsize(input int n);
    case (n)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [15:0] qpop(input int n);
    case (n)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int n, input logic [15:0] d);
    case (n)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) mdata[i] = '0;
    mcnt = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_valid_%0d", tag, i), 32'(vout(i)), 32'd0);
      check($sformatf("%s_data_%0d", tag, i), 32'(dout(i)), 32'd0);
    end
    check($sformatf("%s_count", tag), 32'(bus.xfer_count), 32'd0);
  endtask

  // One cycle: drive just after the falling edge, compare, update the model, advance.
  task automatic step(input logic [15:0] din, input logic v, input logic s1, input logic s2,
                      input logic r0, input logic r1, input logic r2);
    logic [1:0]  sel;
    logic [2:0]  r;
    logic [2:0]  full;
    logic        exp_rdy;
    logic [15:0] popped;
    bus.demux_input = din;
    bus.in_valid    = v;
    bus.selector_1  = s1;
    bus.selector_2  = s2;
    bus.out_ready_0 = r0;
    bus.out_ready_1 = r1;
    bus.out_ready_2 = r2;
    #1;
    r = {r2, r1, r0};
    for (int i = 0; i < 3; i++) full[i] = (qsize(i) != 0);
    sel = s2 ? 2'd2 : (s1 ? 2'd1 : 2'd0);
    exp_rdy = !full[sel] || r[sel];
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("out_valid_%0d", i), 32'(vout(i)), 32'(full[i]));
      check($sformatf("out_data_%0d", i), 32'(dout(i)), 32'(mdata[i]));
    end
    check("xfer_count", 32'(bus.xfer_count), 32'(mcnt));
    for (int i = 0; i < 3; i++) begin
      if (full[i] && r[i]) begin
        popped = qpop(i);
        check($sformatf("deliver_%0d", i), 32'(dout(i)), 32'(popped));
        delivered[i]++;
      end
    end
    if (v && exp_rdy) begin
      qpush(int'(sel), din);
      mdata[sel] = din;
      mcnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int d_before;

  initial begin
    bus.demux_input = '0;
    bus.in_valid    = 1'b0;
    bus.selector_1  = 1'b0;
    bus.selector_2  = 1'b0;
    bus.out_ready_0 = 1'b0;
    bus.out_ready_1 = 1'b0;
    bus.out_ready_2 = 1'b0;
    for (int i = 0; i < 3; i++) delivered[i] = 0;
    model_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset_n = 1'b1;

    // Both selectors set: channel 2 wins.
    step(16'h1234, 1, 1, 1, 0, 0, 0);
    check("t2_data2", 32'(bus.out_data_2), 32'h1234);
    check("t2_valid2", 32'(bus.out_valid_2), 32'd1);
    check("t2_count", 32'(bus.xfer_count), 32'd1);
    step(16'h0000, 0, 0, 0, 0, 0, 1);

    // Stalled ch0 blocks only ch0 words; ch1 still flows.
    step(16'hAAAA, 1, 0, 0, 0, 0, 0);
    step(16'h5555, 1, 0, 0, 0, 0, 0);
    check("t3_hold0", 32'(bus.out_data_0), 32'hAAAA);
    step(16'h7777, 1, 1, 0, 0, 0, 0);
    check("t3_data1", 32'(bus.out_data_1), 32'h7777);
    step(16'h0000, 0, 0, 0, 1, 1, 0);

    // Refill in the delivery cycle, then a 10-word stream.
    step(16'h0001, 1, 1, 0, 0, 0, 0);
    step(16'h0002, 1, 1, 0, 0, 1, 0);
    check("t4_data1", 32'(bus.out_data_1), 32'h0002);
    check("t4_valid1", 32'(bus.out_valid_1), 32'd1);
    d_before = delivered[1];
    for (int i = 0; i < 10; i++) step(16'h0100 + 16'(i), 1, 1, 0, 0, 1, 0);
    check("t4_stream_delivered", 32'(delivered[1] - d_before), 32'd10);
    step(16'h0000, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle with words held in ch0 and ch2.
    step(16'hBEEF, 1, 0, 0, 0, 0, 0);
    step(16'hCAFE, 1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(16'h0000, 0, 0, 0, 1, 1, 1);

    // Counter wrap.
    for (int i = 0; i < 65535; i++) step(16'(i), 1, 0, 0, 1, 0, 0);
    check("t5_count_max", 32'(bus.xfer_count), 32'hFFFF);
    step(16'hFFFF, 1, 0, 0, 1, 0, 0);
    check("t5_count_wrap", 32'(bus.xfer_count), 32'h0000);
    step(16'h0000, 0, 0, 0, 1, 1, 1);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(16'h0000, 0, 0, 0, 1, 1, 1);
    step(16'h0000, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++)
      check($sformatf("final_empty_%0d", i), 32'(vout(i)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
